// File: rtl/change_dispenser_if.sv
// Bundles the request pulse, drink strobe and coin-hopper handshake of the change dispenser.
// The slave side is the dispenser; the master side is the upstream controller plus hopper.
interface change_dispenser_if;
    logic       enable_i;
    logic [1:0] drink_i;
    logic [5:0] change_i;
    logic       coin_ready_i;
    logic       busy_o;
    logic       drink_valid_o;
    logic [1:0] drink_o;
    logic       coin_valid_o;
    logic [1:0] coin_o;
    logic       done_o;
    logic       overrun_o;
    logic [7:0] stock10_o;
    logic [7:0] stock5_o;

    modport master (
        output enable_i, drink_i, change_i, coin_ready_i,
        input  busy_o, drink_valid_o, drink_o, coin_valid_o, coin_o,
               done_o, overrun_o, stock10_o, stock5_o
    );

    modport slave (
        input  enable_i, drink_i, change_i, coin_ready_i,
        output busy_o, drink_valid_o, drink_o, coin_valid_o, coin_o,
               done_o, overrun_o, stock10_o, stock5_o
    );
endinterface

// File: rtl/change_dispenser.sv
// Releases a drink and pays its change as 10/5/1-unit coins over a valid/ready handshake,
// drawing from a finite stock of 10- and 5-unit coins (1-unit coins are unlimited).
module change_dispenser #(
    parameter logic [7:0] STOCK10 = 8'd8,
    parameter logic [7:0] STOCK5  = 8'd8
) (
    input logic              clk,
    input logic              reset,
    change_dispenser_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRINK, COIN, DONE} state_t;

    localparam logic [1:0] COIN_1  = 2'd1;
    localparam logic [1:0] COIN_5  = 2'd2;
    localparam logic [1:0] COIN_10 = 2'd3;

    state_t     state, state_next;
    logic [5:0] rem, rem_next;
    logic [1:0] drink_q, drink_next;
    logic [7:0] stock10, stock10_next;
    logic [7:0] stock5, stock5_next;
    logic       overrun, overrun_next;
    logic [1:0] coin_sel;
    logic [5:0] coin_value;

    // Coin choice depends only on registered rem/stock, so coin_o is stable during a stall.
    always_comb begin
        coin_sel   = COIN_1;
        coin_value = 6'd1;
        if (rem >= 6'd10 && stock10 != 8'd0) begin
            coin_sel   = COIN_10;
            coin_value = 6'd10;
        end else if (rem >= 6'd5 && stock5 != 8'd0) begin
            coin_sel   = COIN_5;
            coin_value = 6'd5;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        state_next   = state;
        rem_next     = rem;
        drink_next   = drink_q;
        stock10_next = stock10;
        stock5_next  = stock5;
        overrun_next = overrun;

        if (bus.enable_i && state != IDLE) overrun_next = 1'b1;

        case (state)
            IDLE: begin
                if (bus.enable_i) begin
                    drink_next = bus.drink_i;
                    rem_next   = bus.change_i;
                    state_next = DRINK;
                end
            end
            DRINK: state_next = (rem != 6'd0) ? COIN : DONE;
            COIN: begin
                if (bus.coin_ready_i) begin
                    rem_next = rem - coin_value;
                    if (coin_sel == COIN_10)
                        stock10_next = (stock10 != 8'd0) ? stock10 - 8'd1 : 8'd0;
                    else if (coin_sel == COIN_5)
                        stock5_next = (stock5 != 8'd0) ? stock5 - 8'd1 : 8'd0;
                    if (rem_next == 6'd0) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            rem     <= 6'd0;
            drink_q <= 2'd0;
            stock10 <= STOCK10;
            stock5  <= STOCK5;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            rem     <= rem_next;
            drink_q <= drink_next;
            stock10 <= stock10_next;
            stock5  <= stock5_next;
            overrun <= overrun_next;
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    assign bus.busy_o        = (state != IDLE);
    assign bus.drink_valid_o = (state == DRINK) && (drink_q != 2'd0);
    assign bus.drink_o       = (state == DRINK) ? drink_q : 2'd0;
    assign bus.coin_valid_o  = (state == COIN);
    assign bus.coin_o        = (state == COIN) ? coin_sel : 2'd0;
    assign bus.done_o        = (state == DONE);
    assign bus.overrun_o     = overrun;
    assign bus.stock10_o     = stock10;
    assign bus.stock5_o      = stock5;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: two instances (default stock, and 10x1/5x0) share one stimulus
// stream and are checked every cycle against a transaction-level coin-plan model.
module tb_change_dispenser;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] drink;
    logic [5:0] change;
    logic       coin_ready;

    always #5 clk = ~clk;

    change_dispenser_if if_a ();
    change_dispenser_if if_b ();

    assign if_a.enable_i     = enable;
    assign if_a.drink_i      = drink;
    assign if_a.change_i     = change;
    assign if_a.coin_ready_i = coin_ready;
    assign if_b.enable_i     = enable;
    assign if_b.drink_i      = drink;
    assign if_b.change_i     = change;
    assign if_b.coin_ready_i = coin_ready;

    change_dispenser dut_a (.clk(clk), .reset(reset), .bus(if_a));
    change_dispenser #(.STOCK10(8'd1), .STOCK5(8'd0)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        int busy, dv, drink, cv, coin, done, ovr, s10, s5;
    } obs_t;

    function automatic obs_t sample(input int i);
        obs_t o;
        if (i == 0) begin
            o.busy = int'(if_a.busy_o);     o.dv   = int'(if_a.drink_valid_o);
            o.drink = int'(if_a.drink_o);   o.cv   = int'(if_a.coin_valid_o);
            o.coin = int'(if_a.coin_o);     o.done = int'(if_a.done_o);
            o.ovr  = int'(if_a.overrun_o);  o.s10  = int'(if_a.stock10_o);
            o.s5   = int'(if_a.stock5_o);
        end else begin
            o.busy = int'(if_b.busy_o);     o.dv   = int'(if_b.drink_valid_o);
            o.drink = int'(if_b.drink_o);   o.cv   = int'(if_b.coin_valid_o);
            o.coin = int'(if_b.coin_o);     o.done = int'(if_b.done_o);
            o.ovr  = int'(if_b.overrun_o);  o.s10  = int'(if_b.stock10_o);
            o.s5   = int'(if_b.stock5_o);
        end
        return o;
    endfunction

    // Model: a request becomes a precomputed greedy coin plan; the plan is consumed one coin
    // per accepted handshake, bracketed by one drink cycle and one done cycle.
    localparam int S10 [2] = '{8, 1};
    localparam int S5  [2] = '{8, 0};
    bit m_busy [2];
    bit m_drink_cyc [2];
    bit m_done_cyc [2];
    bit m_overrun [2];
    int m_drink [2];
    int m_stock10 [2];
    int m_stock5 [2];
    int m_coins [2][64];
    int m_head [2];
    int m_cnt [2];

    function automatic int code_of(input int value);
        if (value == 10) return 3;
        if (value == 5) return 2;
        return 1;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_busy[i] = 0; m_drink_cyc[i] = 0; m_done_cyc[i] = 0; m_overrun[i] = 0;
                m_drink[i] = 0; m_stock10[i] = S10[i]; m_stock5[i] = S5[i];
                m_head[i] = 0; m_cnt[i] = 0;
            end else if (!m_busy[i]) begin
                if (enable) begin
                    int r, s10, s5;
                    r = int'(change); s10 = m_stock10[i]; s5 = m_stock5[i];
                    m_head[i] = 0; m_cnt[i] = 0;
                    while (r > 0) begin
                        if (r >= 10 && s10 > 0) begin m_coins[i][m_cnt[i]] = 10; s10--; r -= 10; end
                        else if (r >= 5 && s5 > 0) begin m_coins[i][m_cnt[i]] = 5; s5--; r -= 5; end
                        else begin m_coins[i][m_cnt[i]] = 1; r -= 1; end
                        m_cnt[i]++;
                    end
                    m_busy[i] = 1; m_drink_cyc[i] = 1; m_drink[i] = int'(drink);
                end
            end else begin
                if (enable) m_overrun[i] = 1;
                if (m_drink_cyc[i]) begin
                    m_drink_cyc[i] = 0;
                    if (m_cnt[i] == 0) m_done_cyc[i] = 1;
                end else if (m_done_cyc[i]) begin
                    m_done_cyc[i] = 0; m_busy[i] = 0;
                end else if (coin_ready) begin
                    if (m_coins[i][m_head[i]] == 10) m_stock10[i]--;
                    else if (m_coins[i][m_head[i]] == 5) m_stock5[i]--;
                    m_head[i]++; m_cnt[i]--;
                    if (m_cnt[i] == 0) m_done_cyc[i] = 1;
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        obs_t o;
        int   exp_cv;
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                o = sample(i);
                exp_cv = int'(m_busy[i] && !m_drink_cyc[i] && !m_done_cyc[i]);
                check($sformatf("busy[%0d]", i), o.busy, int'(m_busy[i]));
                check($sformatf("drink_valid[%0d]", i), o.dv, int'(m_drink_cyc[i] && m_drink[i] != 0));
                check($sformatf("drink[%0d]", i), o.drink, m_drink_cyc[i] ? m_drink[i] : 0);
                check($sformatf("coin_valid[%0d]", i), o.cv, exp_cv);
                check($sformatf("coin[%0d]", i), o.coin, exp_cv != 0 ? code_of(m_coins[i][m_head[i]]) : 0);
                check($sformatf("done[%0d]", i), o.done, int'(m_done_cyc[i]));
                check($sformatf("overrun[%0d]", i), o.ovr, int'(m_overrun[i]));
                check($sformatf("stock10[%0d]", i), o.s10, m_stock10[i]);
                check($sformatf("stock5[%0d]", i), o.s5, m_stock5[i]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic request(input logic [1:0] d, input logic [5:0] c);
        drink = d; change = c; enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            if (!if_a.busy_o && !if_b.busy_o) return;
            tick();
        end
        check("idle_timeout", int'(if_a.busy_o | if_b.busy_o), 0);
    endtask

    initial begin
        obs_t a, b;
        reset = 1'b0; enable = 1'b0; drink = 2'd0; change = 6'd0; coin_ready = 1'b1;
        tick();
        started = 1'b1;
        tick();
        a = sample(0);
        check("reset_busy", a.busy, 0);
        check("reset_coin", a.coin, 0);
        reset = 1'b1;
        tick();

        // drink 2, change 25: 10, 10, 5 then done
        request(2'd2, 6'd25);
        a = sample(0);
        check("t1_drink_valid", a.dv, 1);
        check("t1_drink", a.drink, 2);
        tick(); a = sample(0); check("t1_coin0", a.coin, 3);
        tick(); a = sample(0); check("t1_coin1", a.coin, 3);
        tick(); a = sample(0); check("t1_coin2", a.coin, 2);
        tick(); a = sample(0);
        check("t1_done", a.done, 1);
        check("t1_stock10", a.s10, 6);
        check("t1_stock5", a.s5, 7);
        wait_idle();

        // zero change
        request(2'd1, 6'd0);
        a = sample(0);
        check("t2_drink_valid", a.dv, 1);
        check("t2_no_coin", a.cv, 0);
        tick(); a = sample(0); check("t2_done", a.done, 1);
        tick(); a = sample(0); check("t2_idle", a.busy, 0);
        wait_idle();

        // limited stock instance: 17 -> 10 then seven 1s
        do_reset();
        tick();
        request(2'd0, 6'd17);
        b = sample(1);
        check("t3_no_drink_valid", b.dv, 0);
        for (int k = 0; k < 8; k++) begin
            tick(); b = sample(1);
            check($sformatf("t3_coin%0d", k), b.coin, k == 0 ? 3 : 1);
        end
        tick(); b = sample(1);
        check("t3_done", b.done, 1);
        check("t3_stock10", b.s10, 0);
        wait_idle();

        // stall three cycles on the first coin of 15
        coin_ready = 1'b0;
        request(2'd3, 6'd15);
        for (int k = 0; k < 4; k++) begin
            tick(); a = sample(0);
            check($sformatf("t4_stall%0d", k), a.coin, 3);
        end
        coin_ready = 1'b1;
        tick(); a = sample(0); check("t4_coin5", a.coin, 2);
        tick(); a = sample(0); check("t4_done", a.done, 1);
        wait_idle();

        // overrun during COIN: change 7 -> 5, 1, 1 unaffected
        do_reset();
        tick();
        request(2'd3, 6'd7);
        tick(); a = sample(0); check("t5_coin0", a.coin, 2);
        request(2'd1, 6'd7);
        a = sample(0);
        check("t5_overrun", a.ovr, 1);
        check("t5_coin1", a.coin, 1);
        tick(); a = sample(0); check("t5_coin2", a.coin, 1);
        tick(); a = sample(0); check("t5_done", a.done, 1);
        tick(); a = sample(0);
        check("t5_idle", a.busy, 0);
        check("t5_overrun_sticky", a.ovr, 1);
        check("t5_stock5", a.s5, 7);
        wait_idle();

        // reset mid-COIN after two 10s of 40, then a clean 40
        request(2'd2, 6'd40);
        tick(); tick(); tick();
        reset = 1'b0;
        tick(); a = sample(0);
        check("t6_busy", a.busy, 0);
        check("t6_coin_valid", a.cv, 0);
        check("t6_overrun_cleared", a.ovr, 0);
        check("t6_stock10", a.s10, 8);
        reset = 1'b1;
        tick();
        request(2'd2, 6'd40);
        for (int k = 0; k < 4; k++) begin
            tick(); a = sample(0);
            check($sformatf("t6_coin%0d", k), a.coin, 3);
        end
        tick(); a = sample(0);
        check("t6_done", a.done, 1);
        check("t6_stock10_after", a.s10, 4);
        wait_idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
